// File: rtl/magic_pkg.sv
// Shared types and widths for the MAGIC NOR/INV row sequencer.
package magic_pkg;

  localparam int N_CELLS    = 64;
  localparam int PROG_DEPTH = 64;

  function automatic int field_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int CELL_W  = field_w(N_CELLS);
  localparam int PC_W    = field_w(PROG_DEPTH);
  localparam int INSTR_W = 2 + 3 * CELL_W;

  typedef enum logic [1:0] {
    OP_END  = 2'b00,
    OP_INV1 = 2'b01,
    OP_NOR2 = 2'b10
  } opcode_t;

  typedef enum logic [1:0] {
    XB_INIT     = 2'b00,
    XB_EVAL_INV = 2'b01,
    XB_EVAL_NOR = 2'b10
  } xb_op_t;

  // op is kept as raw bits so the illegal encoding 2'b11 stays representable
  typedef struct packed {
    logic [1:0]        op;
    logic [CELL_W-1:0] dst;
    logic [CELL_W-1:0] src_a;
    logic [CELL_W-1:0] src_b;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_INIT,
    S_EVAL,
    S_DONE,
    S_FAULT
  } state_t;

endpackage

// File: rtl/magic_nor_sequencer_if.sv
// Crossbar driver request/complete handshake.
interface magic_nor_sequencer_if;

  logic                      xb_valid;
  logic                      xb_ready;
  logic [1:0]                xb_op;
  logic [magic_pkg::CELL_W-1:0] xb_dst;
  logic [magic_pkg::CELL_W-1:0] xb_a;
  logic [magic_pkg::CELL_W-1:0] xb_b;

  modport master (output xb_valid, xb_op, xb_dst, xb_a, xb_b, input xb_ready);
  modport slave  (input xb_valid, xb_op, xb_dst, xb_a, xb_b, output xb_ready);

endinterface

// File: rtl/magic_prog_mem.sv
// Gate program store: one synchronous write port, one asynchronous read port.
module magic_prog_mem
  import magic_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  instr_t          wdata,
  input  logic [PC_W-1:0] raddr,
  output instr_t          rdata
);

  instr_t mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/magic_nor_sequencer.sv
// Runs a stored NOR2/INV1 program on one MAGIC crossbar row, INIT then EVAL per gate.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; program memory writable
//   S_FETCH | latch mem[pc] into ir, decode, check abort
//   S_INIT  | request INIT of ir.dst, hold until handshake
//   S_EVAL  | request EVAL_NOR/EVAL_INV, count gate, advance pc
//   S_DONE  | one cycle, pulse done or aborted
//   S_FAULT | one cycle after a bad instruction, err held
module magic_nor_sequencer
  import magic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [PC_W-1:0]       prog_addr,
  input  logic [INSTR_W-1:0]    prog_wdata,
  input  logic                  start,
  input  logic [PC_W-1:0]       start_pc,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err,
  output logic [PC_W-1:0]       err_pc,
  output logic [15:0]           gate_cnt,
  magic_nor_sequencer_if.master xb
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  instr_t          ir;
  instr_t          fetch_word;
  logic            abort_seen;
  logic            fetch_fault;

  magic_prog_mem u_prog_mem (
    .clk   (clk),
    .we    (prog_we && (state == S_IDLE)),
    .waddr (prog_addr),
    .wdata (instr_t'(prog_wdata)),
    .raddr (pc),
    .rdata (fetch_word)
  );

  // Self-overlapping operands would destroy an input while it is being read
  always_comb begin
    fetch_fault = (fetch_word.op == 2'b11)
               || (fetch_word.dst == fetch_word.src_a)
               || ((fetch_word.op == OP_NOR2) && (fetch_word.dst == fetch_word.src_b));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (abort)                        state_nxt = S_DONE;
        else if (fetch_word.op == OP_END) state_nxt = S_DONE;
        else if (fetch_fault)             state_nxt = S_FAULT;
        else                              state_nxt = S_INIT;
      end
      S_INIT:  if (xb.xb_ready) state_nxt = S_EVAL;
      S_EVAL:  if (xb.xb_ready) state_nxt = (pc == PC_LAST) ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    done        = 1'b0;
    aborted     = 1'b0;
    xb.xb_valid = 1'b0;
    xb.xb_op    = XB_INIT;
    xb.xb_dst   = '0;
    xb.xb_a     = '0;
    xb.xb_b     = '0;
    case (state)
      S_INIT: begin
        xb.xb_valid = 1'b1;
        xb.xb_op    = XB_INIT;
        xb.xb_dst   = ir.dst;
      end
      S_EVAL: begin
        xb.xb_valid = 1'b1;
        xb.xb_op    = (ir.op == OP_NOR2) ? XB_EVAL_NOR : XB_EVAL_INV;
        xb.xb_dst   = ir.dst;
        xb.xb_a     = ir.src_a;
        xb.xb_b     = (ir.op == OP_NOR2) ? ir.src_b : '0;
      end
      S_DONE: begin
        done    = !abort_seen;
        aborted = abort_seen;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      ir         <= '0;
      gate_cnt   <= '0;
      err        <= 1'b0;
      err_pc     <= '0;
      abort_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pc         <= start_pc;
          gate_cnt   <= '0;
          err        <= 1'b0;
          abort_seen <= 1'b0;
        end
        S_FETCH: begin
          ir         <= fetch_word;
          abort_seen <= abort;
          if (!abort && (fetch_word.op != OP_END) && fetch_fault) begin
            err    <= 1'b1;
            err_pc <= pc;
          end
        end
        S_EVAL: if (xb.xb_ready) begin
          if (gate_cnt != 16'hFFFF) gate_cnt <= gate_cnt + 16'd1;
          if (pc != PC_LAST) pc <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/magic_nor_sequencer.md
Name: magic_nor_sequencer

Overview:
- Sequences a stored NOR/INV gate program onto one MAGIC memristive crossbar row, one gate at a time.
- Each gate runs as two crossbar operations: INIT, which sets the output cell to logic 1, then EVAL, which applies the NOR or INV voltage.
- Sits between the host/loader, which writes the program and issues start, and the crossbar driver, which performs the analog operations.
- Executes technology-mapped netlists built only from nor2/inv1 cells.

Parameters:
- N_CELLS, 64, number of memristor cells in the row; CELL_W = clog2(N_CELLS).
- PROG_DEPTH, 64, number of instruction words; PC_W = clog2(PROG_DEPTH).
- INSTR_W, 2+3*CELL_W, instruction word layout: {opcode[1:0], dst, srcA, srcB}.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  program write strobe; ignored while busy.
- prog_addr  in  PC_W  program write address.
- prog_wdata  in  INSTR_W  instruction word.
- start  in  1  begin execution at start_pc; sampled in IDLE only.
- start_pc  in  PC_W  first instruction address.
- abort  in  1  stop at the next instruction boundary.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.
- err  out  1  sticky fault flag; cleared by rst or an accepted start.
- err_pc  out  PC_W  PC of the faulting instruction.
- gate_cnt  out  16  gates completed in the current run; saturates at 0xFFFF.
- xb_valid  out  1  crossbar operation request.
- xb_ready  in  1  crossbar accepts/completes the operation.
- xb_op  out  2  00 INIT, 01 EVAL_INV, 10 EVAL_NOR.
- xb_dst, xb_a, xb_b  out  CELL_W each  cell indices; xb_b is 0 for INV.

Behaviour:
- Reset values: state=IDLE, pc=0, busy=0, done=0, aborted=0, err=0, err_pc=0, gate_cnt=0, xb_valid=0, xb_op=0, xb_dst/xb_a/xb_b=0. Reset mid-run drops any pending xb request immediately. Program memory is not cleared.
- Opcodes: 00 END, 01 INV1 (uses srcA), 10 NOR2, 11 illegal.
- FSM states: IDLE, FETCH, INIT, EVAL, DONE, FAULT.
- IDLE: on start, pc<=start_pc, gate_cnt<=0, err<=0, go to FETCH.
- FETCH (1 cycle): ir<=mem[pc], then decode:
  - abort=1 -> DONE with aborted pulse; abort has priority over decode.
  - END -> DONE.
  - illegal opcode, or dst==srcA, or (NOR2 and dst==srcB) -> FAULT, err<=1, err_pc<=pc.
  - otherwise -> INIT.
- INIT:
  - xb_valid=1, xb_op=INIT, xb_dst=dst.
  - Hold all xb outputs stable until xb_valid&&xb_ready, then go to EVAL.
- EVAL:
  - xb_valid=1, xb_op=EVAL_NOR/EVAL_INV, xb_dst/xb_a/xb_b from ir.
  - On handshake: gate_cnt++ (saturating).
  - If pc==PROG_DEPTH-1, go to DONE; there is no wrap. Otherwise pc++ and go to FETCH.
- xb_valid is never deasserted before a handshake. abort during INIT or EVAL is ignored until the next FETCH, so a gate is never left half-evaluated.
- DONE (1 cycle): exactly one of done or aborted is pulsed; busy=1; then IDLE.
- FAULT (1 cycle): busy=1, no pulse; then IDLE. err and err_pc hold.
- prog_we with busy=0 writes mem[prog_addr] on the clock edge. A write in the same cycle start is accepted takes effect, and the run sees the new word.
- Timing with xb_ready held at 1:
  - each gate takes 3 cycles (FETCH, INIT, EVAL);
  - a program of G gates plus END gives done 3G+2 cycles after the start cycle.

Decomposition:
- Shared package magic_pkg holds:
  - opcode enum (OP_END, OP_INV1, OP_NOR2);
  - xb_op enum (XB_INIT, XB_EVAL_INV, XB_EVAL_NOR);
  - instr_t packed struct and the field-width function of N_CELLS;
  - FSM state enum.
- One sub-module, magic_prog_mem: a PROG_DEPTH x INSTR_W register array with one write port and one asynchronous read port. Decode and FSM live in the top.

Test Plan:
- XOR program on cells 0,1 -> dst 6 (INV 2<-0; INV 3<-1; NOR 4<-2,3; NOR 5<-0,1; NOR 6<-4,5; END), xb_ready=1 -> 10 handshakes in order INIT/EVAL_INV dst2 a0, ..., INIT/EVAL_NOR dst6 a4 b5; done at cycle 17 after start; gate_cnt=5; err=0.
- Same program, xb_ready low for 4 cycles during gate 3 INIT -> xb outputs stable throughout, no EVAL early, done delayed by exactly 4 cycles.
- Word 2 = opcode 11 -> FAULT after 2 gates; err=1, err_pc=2, gate_cnt=2, no done pulse; next start clears err.
- NOR2 with dst==srcB at pc 0 -> err=1, err_pc=0, zero xb handshakes.
- abort asserted mid-EVAL of gate 1 -> gate 1 completes, aborted pulses, gate_cnt=2 (gates 0 and 1), done=0.
- Program with no END filling all 64 words, start_pc=62 -> gates at 62 and 63 execute, done pulses, pc does not wrap. rst asserted mid-INIT on a rerun -> xb_valid=0 and busy=0 the next cycle.
